// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared widths and FSM state type for the Collatz stopping-time engine
package collatz_pkg;
  localparam int N_W    = 4;
  localparam int WORK_W = 8;
  localparam int OUT_W  = 4;

  localparam logic [OUT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;
endpackage

// File: rtl/collatz_if.sv
// rtl/collatz_if.sv - pin-level bundle: start value in, stopping time and done pulse out
interface collatz_if;
  import collatz_pkg::*;

  logic [N_W-1:0]   n;
  logic [OUT_W-1:0] out;
  logic             done;

  modport master (output n, input out, input done);
  modport slave  (input n, output out, output done);
endinterface

// File: rtl/collatz_next.sv
// rtl/collatz_next.sv - one combinational Collatz step: halve if even, 3x+1 if odd
module collatz_next
  import collatz_pkg::*;
(
  input  logic [WORK_W-1:0] x,
  output logic [WORK_W-1:0] x_next
);
  logic [WORK_W-1:0] triple_plus_one;

  // Wraps in WORK_W bits; the iterate never exceeds 160 for a 4-bit start.
  assign triple_plus_one = (x << 1) + x + WORK_W'(1);

  always_comb begin
    x_next = triple_plus_one;
    if (!x[0]) begin
      x_next = x >> 1;
    end
  end
endmodule

// File: rtl/collatz_seq.sv
// rtl/collatz_seq.sv - sequential Collatz stopping-time engine, one step per clock, saturating count
module collatz_seq
  import collatz_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  collatz_if.slave bus
);
  state_e            state_q, state_d;
  logic [WORK_W-1:0] x_q, x_d;
  logic [OUT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic [WORK_W-1:0] x_step;

  collatz_next u_next (
    .x      (x_q),
    .x_next (x_step)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        x_d     = WORK_W'(bus.n);
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // x==0 is treated as already terminated so n=0 cannot loop forever.
        if (x_q <= WORK_W'(1)) begin
          state_d = FINISH;
        end else begin
          x_d   = x_step;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + OUT_W'(1);
        end
      end
      FINISH: begin
        out_d   = cnt_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_collatz_seq.sv
// tb/tb_collatz_seq.sv - randomized self-checking bench for collatz_seq against an arithmetic model
module tb_collatz_seq;
  import collatz_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  collatz_if bus ();

  collatz_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_steps(input int n);
    int x;
    int s;
    x = n;
    s = 0;
    while (x > 1) begin
      if (x % 2 == 0) x = x / 2;
      else            x = 3 * x + 1;
      s++;
    end
    return s;
  endfunction

  function automatic int ref_out(input int n);
    int s;
    s = ref_steps(n);
    return (s > 15) ? 15 : s;
  endfunction

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (bus.done === 1'b1) ok = 1'b1;
    end
  endtask

  // Returns at a negedge where done is high: the FSM is in IDLE and samples n next edge.
  task automatic sync_idle(input string tag);
    int c;
    bit ok;
    wait_done(60, c, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_sync: done=%0b after %0d cycles, required done pulse", tag, bus.done, c);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    bus.n = 4'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out !== 4'd0) begin
      errors++;
      $display("FAIL reset_out: got %0d required 0", bus.out);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %0b required 0", bus.done);
    end
    rst = 1'b0;
    sync_idle("reset_n6");
    checks++;
    if (bus.out !== 4'd8) begin
      errors++;
      $display("FAIL reset_n6_out: got %0d required 8", bus.out);
    end
  endtask

  task automatic test_table();
    int vals [8] = '{3, 5, 8, 9, 15, 1, 0, 11};
    int want [8] = '{7, 5, 3, 15, 15, 0, 0, 14};
    int c;
    bit ok;
    sync_idle("table");
    foreach (vals[i]) begin
      bus.n = vals[i][N_W-1:0];
      wait_done(60, c, ok);
      checks++;
      if (ok !== 1'b1 || bus.out !== want[i][OUT_W-1:0]) begin
        errors++;
        $display("FAIL table_n%0d: out=%0d done_seen=%0b required out=%0d", vals[i], bus.out, ok, want[i]);
      end
      checks++;
      if (c != ref_steps(vals[i]) + 3) begin
        errors++;
        $display("FAIL table_latency_n%0d: got %0d cycles required %0d", vals[i], c, ref_steps(vals[i]) + 3);
      end
    end
  endtask

  task automatic test_random();
    int n;
    int c;
    bit ok;
    sync_idle("rand");
    for (int k = 0; k < 24; k++) begin
      n     = int'($urandom_range(0, 15));
      bus.n = n[N_W-1:0];
      wait_done(60, c, ok);
      checks++;
      if (ok !== 1'b1 || bus.out !== ref_out(n)[OUT_W-1:0] || c != ref_steps(n) + 3) begin
        errors++;
        $display("FAIL rand_n%0d: out=%0d cycles=%0d required out=%0d cycles=%0d",
                 n, bus.out, c, ref_out(n), ref_steps(n) + 3);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL rand_pulse_n%0d: done=%0b one cycle later, required 0", n, bus.done);
      end
      // Resynchronise on the following result so n is sampled at a known IDLE.
      wait_done(60, c, ok);
      checks++;
      if (ok !== 1'b1 || bus.out !== ref_out(n)[OUT_W-1:0]) begin
        errors++;
        $display("FAIL rand_repeat_n%0d: out=%0d done_seen=%0b required out=%0d", n, bus.out, ok, ref_out(n));
      end
    end
  endtask

  task automatic test_n_change();
    int c;
    bit ok;
    sync_idle("change");
    bus.n = 4'd6;
    repeat (4) @(negedge clk);
    bus.n = 4'd11;
    wait_done(60, c, ok);
    checks++;
    if (ok !== 1'b1 || bus.out !== 4'd8) begin
      errors++;
      $display("FAIL change_first: out=%0d done_seen=%0b required 8", bus.out, ok);
    end
    wait_done(60, c, ok);
    checks++;
    if (ok !== 1'b1 || bus.out !== 4'd14) begin
      errors++;
      $display("FAIL change_second: out=%0d done_seen=%0b required 14", bus.out, ok);
    end
  endtask

  task automatic test_rst_mid_run();
    int c;
    bit ok;
    sync_idle("rstrun");
    bus.n = 4'd7;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out !== 4'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rstrun_out: out=%0d done=%0b required out=0 done=0", bus.out, bus.done);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL rstrun_state: got %0d required IDLE", dut.state_q);
    end
    rst = 1'b0;
    wait_done(60, c, ok);
    checks++;
    if (ok !== 1'b1 || bus.out !== 4'd15 || c != ref_steps(7) + 3) begin
      errors++;
      $display("FAIL rstrun_after: out=%0d cycles=%0d required out=15 cycles=%0d", bus.out, c, ref_steps(7) + 3);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.n  = '0;
    test_reset();
    test_table();
    test_random();
    test_n_change();
    test_rst_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
